loop_step_sched: RTL and testbench

Sequencer for the two-variable 8-bit loop datapath (x, y updated per step under a 1-bit selector). On a start request it clears the datapath and issues step strobes with a generated selector pattern. It checks an exit guard after every step and reports the final x/y values and the exit cause. It replaces free-running random selector stimulus with a bounded, repeatable, handshaked run.

---
 rtl/loop_step_sched.sv | 185 ++++++++++++++++++
 tb/tb_loop_step_sched.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/loop_step_sched.sv
// Step sequencer for the x/y loop datapath: clear, strobe, guard/limit exit.
// Define LOOP_SCHED_SELHIST_EN to count steps issued with selector=1.
module loop_step_sched #(
  parameter int WIDTH = 8,
  parameter int ITER_W = 10,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ITER_W-1:0] iter_max,
  input  logic [1:0]        sel_mode,
  input  logic [WIDTH-1:0]  guard_limit,
  input  logic [WIDTH-1:0]  x_in,
  input  logic [WIDTH-1:0]  y_in,
  output logic              dp_clear,
  output logic              dp_step,
  output logic              dp_selector,
  output logic              busy,
  output logic              done,
  output logic [1:0]        exit_cause,
  output logic [ITER_W-1:0] iter_count,
  output logic [WIDTH-1:0]  x_final,
  output logic [WIDTH-1:0]  y_final,
  output logic [ITER_W-1:0] sel1_count
);

  typedef enum logic [2:0] {
    IDLE, INIT, STEP, CHECK, DONE
  } state_t;

  localparam logic [1:0] C_LIMIT = 2'd1;
  localparam logic [1:0] C_GUARD = 2'd2;
  localparam logic [1:0] C_ABORT = 2'd3;

  // An all-zero LFSR would lock up, so a zero seed is forced to 1.
  localparam logic [7:0] SEED =
    (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  state_t            state;
  logic [7:0]        lfsr;
  logic              phase;
  logic [ITER_W-1:0] iter_max_q;
  logic [1:0]        sel_mode_q;
  logic [WIDTH-1:0]  guard_q;

  logic              go_step;
  logic              go_done;
  logic [1:0]        cause_nxt;
  logic              sel_nxt;
  logic [7:0]        lfsr_nxt;

  assign lfsr_nxt = {lfsr[6:0],
                     lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  always_comb begin
    sel_nxt = 1'b0;
    case (sel_mode_q)
      2'd0: sel_nxt = 1'b0;
      2'd1: sel_nxt = 1'b1;
      2'd2: sel_nxt = phase;
      default: sel_nxt = lfsr[0];
    endcase
  end

  // Exit priority: abort, then guard, then limit.
  always_comb begin
    go_step = 1'b0;
    go_done = 1'b0;
    cause_nxt = 2'd0;
    case (state)
      INIT: begin
        if (abort) begin
          go_done = 1'b1;
          cause_nxt = C_ABORT;
        end else if (iter_max_q == '0) begin
          go_done = 1'b1;
          cause_nxt = C_LIMIT;
        end else begin
          go_step = 1'b1;
        end
      end
      STEP: begin
        if (abort) begin
          go_done = 1'b1;
          cause_nxt = C_ABORT;
        end
      end
      CHECK: begin
        if (abort) begin
          go_done = 1'b1;
          cause_nxt = C_ABORT;
        end else if (x_in >= guard_q) begin
          go_done = 1'b1;
          cause_nxt = C_GUARD;
        end else if (iter_count == iter_max_q) begin
          go_done = 1'b1;
          cause_nxt = C_LIMIT;
        end else begin
          go_step = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef LOOP_SCHED_SELHIST_EN
  logic [ITER_W-1:0] sel_cnt;
  assign sel1_count = sel_cnt;
`else
  assign sel1_count = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      lfsr        <= SEED;
      phase       <= 1'b0;
      iter_max_q  <= '0;
      sel_mode_q  <= '0;
      guard_q     <= '0;
      dp_clear    <= 1'b0;
      dp_step     <= 1'b0;
      dp_selector <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      exit_cause  <= '0;
      iter_count  <= '0;
      x_final     <= '0;
      y_final     <= '0;
`ifdef LOOP_SCHED_SELHIST_EN
      sel_cnt     <= '0;
`endif
    end else begin
      dp_clear <= 1'b0;
      dp_step  <= 1'b0;
      done     <= 1'b0;
      if (go_step) begin
        state       <= STEP;
        dp_step     <= 1'b1;
        dp_selector <= sel_nxt;
        iter_count  <= iter_count + ITER_W'(1);
        phase       <= ~phase;
        lfsr        <= lfsr_nxt;
`ifdef LOOP_SCHED_SELHIST_EN
        if (sel_nxt) sel_cnt <= sel_cnt + ITER_W'(1);
`endif
      end else if (go_done) begin
        state      <= DONE;
        done       <= 1'b1;
        exit_cause <= cause_nxt;
        x_final    <= x_in;
        y_final    <= y_in;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state      <= INIT;
              iter_max_q <= iter_max;
              sel_mode_q <= sel_mode;
              guard_q    <= guard_limit;
              iter_count <= '0;
              exit_cause <= '0;
              dp_clear   <= 1'b1;
              busy       <= 1'b1;
              lfsr       <= SEED;
              phase      <= 1'b0;
`ifdef LOOP_SCHED_SELHIST_EN
              sel_cnt    <= '0;
`endif
            end
          end
          STEP: state <= CHECK;
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_loop_step_sched.sv
// Directed bench for loop_step_sched with a small x/y datapath model.
// Hand-computed expectations; LFSR selectors derived from seed 8'hA5.
module tb_loop_step_sched;

`ifdef LOOP_SCHED_SELHIST_EN
  localparam bit SELH = 1'b1;
`else
  localparam bit SELH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [9:0] iter_max = '0;
  logic [1:0] sel_mode = '0;
  logic [7:0] guard_limit = '0;
  logic [7:0] x = '0;
  logic [7:0] y = '0;

  logic       dp_clear, dp_step, dp_selector, busy, done;
  logic [1:0] exit_cause;
  logic [9:0] iter_count, sel1_count;
  logic [7:0] x_final, y_final;

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  loop_step_sched dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .iter_max(iter_max), .sel_mode(sel_mode),
    .guard_limit(guard_limit), .x_in(x), .y_in(y),
    .dp_clear(dp_clear), .dp_step(dp_step),
    .dp_selector(dp_selector), .busy(busy), .done(done),
    .exit_cause(exit_cause), .iter_count(iter_count),
    .x_final(x_final), .y_final(y_final),
    .sel1_count(sel1_count)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    cyc <= cyc + 1;
    if (dp_clear) begin
      x <= '0;
      y <= '0;
    end else if (dp_step) begin
      if (dp_selector) y <= y + 8'd1;
      else x <= x + 8'd1;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one request; times are relative to the edge that saw start
  // (INIT observed at 1, first step at 2, ...).
  int         ns, nclr, first_rel, last_rel, done_rel, to;
  logic [31:0] selpat;

  task automatic run(input logic [9:0] im, input logic [1:0] sm,
                     input logic [7:0] gl, input int abort_at,
                     input bit noise);
    int t0;
    ns = 0; nclr = 0; first_rel = 0; last_rel = 0;
    done_rel = 0; to = 1; selpat = '0;
    @(negedge clk);
    iter_max = im; sel_mode = sm; guard_limit = gl;
    start = 1'b1;
    t0 = cyc + 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      if (dp_clear) nclr++;
      if (dp_step) begin
        selpat[ns] = dp_selector;
        if (ns == 0) first_rel = cyc - t0 + 1;
        last_rel = cyc - t0 + 1;
        ns++;
        if (ns == abort_at) abort = 1'b1;
        if (noise && ns == 2) begin
          start = 1'b1;
          iter_max = 10'd1;
          sel_mode = 2'd0;
        end
      end
      if (done) begin
        done_rel = cyc - t0 + 1;
        to = 0;
        break;
      end
    end
    check("timeout", to, 0);
  endtask

  initial begin
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_step", {dp_step, dp_clear, dp_selector}, 0);
    check("rst_cause", exit_cause, 0);
    check("rst_iter", iter_count, 0);
    check("rst_final", {x_final, y_final}, 0);
    check("rst_sel1", sel1_count, 0);
    @(negedge clk);
    rst = 1'b1;

    // Zero-step run straight after reset, datapath still zero
    run(10'd0, 2'd0, 8'd255, 0, 0);
    check("z_clear", nclr, 1);
    check("z_steps", ns, 0);
    check("z_done_t", done_rel, 2);
    check("z_cause", exit_cause, 1);
    check("z_final", {x_final, y_final}, 0);
    check("z_iter", iter_count, 0);
    check("z_busy", busy, 1);
    @(negedge clk);
    check("z_done_pulse", {done, busy}, 0);

    run(10'd5, 2'd0, 8'd255, 0, 0);
    check("c0_steps", ns, 5);
    check("c0_first", first_rel, 2);
    check("c0_last", last_rel, 10);
    check("c0_done_t", done_rel, 12);
    check("c0_cause", exit_cause, 1);
    check("c0_x", x_final, 5);
    check("c0_y", y_final, 0);
    check("c0_iter", iter_count, 5);
    check("c0_sel", selpat, 0);

    run(10'd6, 2'd2, 8'd255, 0, 0);
    check("alt_sel", selpat, 32'h2A);
    check("alt_x", x_final, 3);
    check("alt_y", y_final, 3);
    check("alt_sel1", sel1_count, SELH ? 3 : 0);
    check("alt_done_t", done_rel, 14);

    run(10'd100, 2'd0, 8'd4, 0, 0);
    check("g_cause", exit_cause, 2);
    check("g_x", x_final, 4);
    check("g_iter", iter_count, 4);
    check("g_done_t", done_rel, 10);

    // Seed A5 gives selectors 1,0,1; abort on the 3rd strobe
    for (int r = 0; r < 2; r++) begin
      run(10'd20, 2'd3, 8'd255, 3, 0);
      check("ab_cause", exit_cause, 3);
      check("ab_iter", iter_count, 3);
      check("ab_steps", ns, 3);
      check("ab_sel", selpat, 32'h5);
      check("ab_final", {x_final, y_final}, 16'h0101);
      check("ab_done_t", done_rel, 7);
      check("ab_sel1", sel1_count, SELH ? 2 : 0);
    end

    run(10'd4, 2'd1, 8'd255, 0, 1);
    check("nz_steps", ns, 4);
    check("nz_sel", selpat, 32'hF);
    check("nz_final", {x_final, y_final}, 16'h0004);
    check("nz_cause", exit_cause, 1);
    check("nz_done_t", done_rel, 10);
    check("nz_sel1", sel1_count, SELH ? 4 : 0);
    @(negedge clk);
    check("nz_idle", {busy, dp_clear}, 0);

    // Reset during CHECK
    @(negedge clk);
    iter_max = 10'd10; sel_mode = 2'd0; guard_limit = 8'd255;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ns = 0;
    for (int i = 0; i < 40 && ns < 2; i++) begin
      @(negedge clk);
      if (dp_step) ns++;
    end
    @(negedge clk);
    check("mr_busy", busy, 1);
    check("mr_iter", iter_count, 2);
    #2 rst = 1'b0;
    #1;
    check("mr_rst_busy", busy, 0);
    check("mr_rst_iter", iter_count, 0);
    check("mr_rst_out", {dp_step, dp_clear, done, exit_cause}, 0);
    check("mr_rst_final", {x_final, y_final}, 0);
    @(negedge clk);
    rst = 1'b1;

    run(10'd3, 2'd0, 8'd255, 0, 0);
    check("pr_cause", exit_cause, 1);
    check("pr_x", x_final, 3);
    check("pr_iter", iter_count, 3);
    check("pr_done_t", done_rel, 8);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
